// File: rtl/led_step_ctrl.sv
// Step sequencer for the dynamic LED colour block: button or auto-timer -> one-cycle step pulses.
// Optional button debounce filter enabled by defining LED_STEP_CTRL_DEBOUNCE_EN.
module led_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int AUTO_PERIOD     = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_btn_raw,
    input  logic       i_auto_en,
    input  logic       i_pause,
    output logic       o_step,
    output logic [2:0] o_colour_exp,
    output logic [7:0] o_step_cnt,
    output logic       o_auto_active
);

    typedef enum logic [1:0] {
        S_MAN,
        S_AUTO,
        S_PAUSE
    } state_t;

    localparam logic [23:0] TIMER_LAST = 24'(AUTO_PERIOD - 1);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
        $error("led_step_ctrl: DEBOUNCE_CYCLES out of range");
    end
    if (AUTO_PERIOD < 2 || AUTO_PERIOD > 16777215) begin : g_bad_period
        $error("led_step_ctrl: AUTO_PERIOD out of range");
    end

    state_t      r_state;
    state_t      w_state_next;
    logic [23:0] r_timer;
    logic [23:0] w_timer_next;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_btn_db_d;
    logic        w_btn_db;
    logic        w_btn_rise;
    logic        w_req;
    logic        r_step;
    logic [2:0]  r_colour;
    logic [7:0]  r_cnt;
    logic        r_auto_active;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_btn_db_d <= 1'b0;
        end else begin
            r_sync1    <= i_btn_raw;
            r_sync2    <= r_sync1;
            r_btn_db_d <= w_btn_db;
        end
    end

`ifdef LED_STEP_CTRL_DEBOUNCE_EN
    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [15:0] r_db_cnt;
    logic        r_btn_db;

    // A new level is accepted only after it has disagreed with the filtered level long enough.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_db_cnt <= '0;
            r_btn_db <= 1'b0;
        end else if (r_sync2 == r_btn_db) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == DB_LAST) begin
            r_btn_db <= r_sync2;
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + 16'd1;
        end
    end

    assign w_btn_db = r_btn_db;
`else
    assign w_btn_db = r_sync2;
`endif

    assign w_btn_rise = w_btn_db & ~r_btn_db_d;

    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_req        = 1'b0;
        case (r_state)
            S_MAN: begin
                w_req        = w_btn_rise;
                w_timer_next = '0;
                if (i_pause) begin
                    w_state_next = S_PAUSE;
                end else if (i_auto_en) begin
                    w_state_next = S_AUTO;
                end
            end
            S_AUTO: begin
                if (w_btn_rise || r_timer == TIMER_LAST) begin
                    w_req        = 1'b1;
                    w_timer_next = '0;
                end else begin
                    w_timer_next = r_timer + 24'd1;
                end
                // Pausing freezes the phase, but a step issued on this cycle still restarts it.
                if (i_pause) begin
                    w_state_next = S_PAUSE;
                    if (!w_req) begin
                        w_timer_next = r_timer;
                    end
                end else if (!i_auto_en) begin
                    w_state_next = S_MAN;
                    w_timer_next = '0;
                end
            end
            S_PAUSE: begin
                if (!i_pause) begin
                    if (i_auto_en) begin
                        w_state_next = S_AUTO;
                    end else begin
                        w_state_next = S_MAN;
                        w_timer_next = '0;
                    end
                end
            end
            default: begin
                w_state_next = S_MAN;
                w_timer_next = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_MAN;
            r_timer       <= '0;
            r_step        <= 1'b0;
            r_colour      <= 3'd0;
            r_cnt         <= 8'd0;
            r_auto_active <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_timer       <= w_timer_next;
            r_step        <= w_req;
            r_auto_active <= (w_state_next == S_AUTO);
            if (w_req) begin
                r_colour <= (r_colour == 3'd0 || r_colour >= 3'd6) ? 3'd1 : r_colour + 3'd1;
                r_cnt    <= r_cnt + 8'd1;
            end
        end
    end

    assign o_step        = r_step;
    assign o_colour_exp  = r_colour;
    assign o_step_cnt    = r_cnt;
    assign o_auto_active = r_auto_active;

endmodule

// File: tb/tb_led_step_ctrl.sv
// Self-checking bench for led_step_ctrl: directed scenarios plus random stimulus,
// compared every cycle against a behavioural model of the sequencer.
module tb_led_step_ctrl;

    localparam int DB = 4;
    localparam int AP = 8;
`ifdef LED_STEP_CTRL_DEBOUNCE_EN
    localparam bit DB_ON = 1'b1;
`else
    localparam bit DB_ON = 1'b0;
`endif

    localparam int MODE_MANUAL = 0;
    localparam int MODE_AUTO   = 1;
    localparam int MODE_PAUSED = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btnRaw = 1'b0;
    logic       autoEn = 1'b0;
    logic       pauseIn = 1'b0;
    logic       step;
    logic [2:0] colourExp;
    logic [7:0] stepCnt;
    logic       autoActive;

    int checks = 0;
    int errors = 0;

    led_step_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .AUTO_PERIOD    (AP)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_btn_raw    (btnRaw),
        .i_auto_en    (autoEn),
        .i_pause      (pauseIn),
        .o_step       (step),
        .o_colour_exp (colourExp),
        .o_step_cnt   (stepCnt),
        .o_auto_active(autoActive)
    );

    always #5 clk = ~clk;

    // Behavioural model state: steps issued since reset, mode, cycles left to the next auto step.
    bit mValid = 1'b0;
    bit mSyncHist [0:1];
    bit mDbLevel;
    int mMismatch;
    bit mPrevLevel;
    int mMode;
    int mRemaining;
    int mSteps;
    bit mStep;
    bit mAutoActive;

    function automatic int expColour(input int steps);
        return (steps == 0) ? 0 : ((steps - 1) % 6) + 1;
    endfunction

    always @(posedge clk) begin : model
        bit btnS;
        bit level;
        bit rise;
        bit req;
        if (rst) begin
            mValid      = 1'b1;
            mSyncHist[0] = 1'b0;
            mSyncHist[1] = 1'b0;
            mDbLevel    = 1'b0;
            mMismatch   = 0;
            mPrevLevel  = 1'b0;
            mMode       = MODE_MANUAL;
            mRemaining  = AP - 1;
            mSteps      = 0;
            mStep       = 1'b0;
            mAutoActive = 1'b0;
        end else begin
            btnS  = mSyncHist[1];
            level = DB_ON ? mDbLevel : btnS;
            rise  = level && !mPrevLevel;
            req   = 1'b0;
            if (mMode == MODE_MANUAL) begin
                req = rise;
                mRemaining = AP - 1;
                if (pauseIn) mMode = MODE_PAUSED;
                else if (autoEn) mMode = MODE_AUTO;
            end else if (mMode == MODE_AUTO) begin
                int nextRem;
                if (rise || mRemaining == 0) begin
                    req = 1'b1;
                    nextRem = AP - 1;
                end else begin
                    nextRem = mRemaining - 1;
                end
                if (pauseIn) begin
                    mMode = MODE_PAUSED;
                    if (req) mRemaining = AP - 1;
                end else if (!autoEn) begin
                    mMode = MODE_MANUAL;
                    mRemaining = AP - 1;
                end else begin
                    mRemaining = nextRem;
                end
            end else begin
                if (!pauseIn) begin
                    if (autoEn) mMode = MODE_AUTO;
                    else begin
                        mMode = MODE_MANUAL;
                        mRemaining = AP - 1;
                    end
                end
            end
            if (btnS == mDbLevel) mMismatch = 0;
            else if (mMismatch + 1 >= DB) begin
                mDbLevel  = btnS;
                mMismatch = 0;
            end else mMismatch++;
            mPrevLevel   = level;
            mSyncHist[1] = mSyncHist[0];
            mSyncHist[0] = btnRaw;
            mStep        = req;
            if (req) mSteps++;
            mAutoActive  = (mMode == MODE_AUTO);
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit b, input bit a, input bit p);
        rst     = r;
        btnRaw  = b;
        autoEn  = a;
        pauseIn = p;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (mValid) begin
            checkOutput("model_step", int'(step), int'(mStep));
            checkOutput("model_colour", int'(colourExp), expColour(mSteps));
            checkOutput("model_cnt", int'(stepCnt), mSteps % 256);
            checkOutput("model_auto_active", int'(autoActive), int'(mAutoActive));
        end
    end

    initial begin
        int pulses;
        int firstK;
        int lastK;
        bit sawWrap;
        int prevColour;
        int btnHold;

        // Reset held for two edges, then released.
        applyStimulus(1, 0, 0, 0);
        tick(2);
        applyStimulus(0, 0, 0, 0);
        tick(1);
        checkOutput("reset_step", int'(step), 0);
        checkOutput("reset_colour", int'(colourExp), 0);
        checkOutput("reset_cnt", int'(stepCnt), 0);
        checkOutput("reset_auto_active", int'(autoActive), 0);

        // Held press in manual mode.
        applyStimulus(0, 1, 0, 0);
        pulses = 0;
        firstK = 0;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            if (step) begin
                pulses++;
                if (firstK == 0) firstK = k;
            end
        end
        checkOutput("press_latency", firstK, DB_ON ? 3 + DB : 3);
        checkOutput("press_pulses", pulses, 1);
        checkOutput("press_colour", int'(colourExp), 1);
        checkOutput("press_cnt", int'(stepCnt), 1);
        applyStimulus(0, 0, 0, 0);
        tick(12);

        // Fast chatter: two cycles high, two low.
        pulses = 0;
        for (int k = 0; k < 28; k++) begin
            if (k < 16) btnRaw = ((k / 2) % 2 == 0);
            else btnRaw = 1'b0;
            tick(1);
            if (step) pulses++;
        end
        checkOutput("chatter_pulses", pulses, DB_ON ? 0 : 4);

        // Auto-advance for 100 cycles.
        applyStimulus(0, 0, 1, 0);
        pulses = 0;
        lastK = 0;
        sawWrap = 1'b0;
        prevColour = int'(colourExp);
        for (int k = 1; k <= 100; k++) begin
            tick(1);
            if (step) begin
                pulses++;
                if (lastK != 0) checkOutput("auto_interval", k - lastK, AP);
                lastK = k;
                if (prevColour == 6 && colourExp == 3'd1) sawWrap = 1'b1;
                prevColour = int'(colourExp);
            end
        end
        checkOutput("auto_pulses", pulses, 12);
        checkOutput("auto_colour_wrap", int'(sawWrap), 1);
        checkOutput("auto_cnt", int'(stepCnt), DB_ON ? 13 : 17);
        applyStimulus(0, 0, 0, 0);
        tick(5);

        // Pause with the auto phase at 5.
        applyStimulus(0, 0, 1, 0);
        tick(6);
        applyStimulus(0, 0, 1, 1);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (step) pulses++;
            checkOutput("pause_auto_active", int'(autoActive), 0);
        end
        checkOutput("pause_pulses", pulses, 0);
        applyStimulus(0, 0, 1, 0);
        firstK = 0;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            if (step && firstK == 0) firstK = k;
        end
        // One edge restores auto mode, then the phase needs 5 -> 6 -> 7 -> step.
        checkOutput("resume_latency", firstK, 4);
        applyStimulus(0, 0, 0, 0);
        tick(3);

        // Counter wrap after 256 auto steps, then a mid-period reset.
        applyStimulus(1, 0, 0, 0);
        tick(1);
        applyStimulus(0, 0, 1, 0);
        pulses = 0;
        for (int k = 0; k < 256 * AP + 40 && pulses < 256; k++) begin
            tick(1);
            if (step) pulses++;
        end
        checkOutput("wrap_pulses", pulses, 256);
        checkOutput("wrap_cnt", int'(stepCnt), 0);
        checkOutput("wrap_colour", int'(colourExp), 4);
        tick(3);
        applyStimulus(1, 0, 0, 0);
        tick(1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("midreset_step", int'(step), 0);
        checkOutput("midreset_cnt", int'(stepCnt), 0);
        checkOutput("midreset_colour", int'(colourExp), 0);
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (step) pulses++;
        end
        checkOutput("midreset_pulses", pulses, 0);
        checkOutput("midreset_auto_active", int'(autoActive), 0);

        // Random traffic against the model.
        btnHold = 0;
        for (int k = 0; k < 1500; k++) begin
            if (btnHold == 0) begin
                btnRaw  = ~btnRaw;
                btnHold = $urandom_range(1, 12);
            end else begin
                btnHold--;
            end
            if ($urandom_range(0, 39) == 0) autoEn = ~autoEn;
            if ($urandom_range(0, 29) == 0) pauseIn = ~pauseIn;
            rst = ($urandom_range(0, 299) == 0);
            tick(1);
        end
        applyStimulus(0, 0, 0, 0);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
